acc_sequencer: RTL and testbench
================================

Name: acc_sequencer

Overview:
- Controller that sequences the accumulator datapath (signal_load / signal_init / signal_neg / signal_oe, data_in, attr_in) for one burst of operands per command.
- Accepts a start command with an operand count, then takes operands over a valid/ready handshake.
- Drives each operand onto the datapath for HOLD_CYCLES clocks, then asserts output-enable and reports completion.
- Replaces hand-written bench tasks as the standard way the accumulator is driven in-system.

Parameters:
- DATA_WIDTH, 8, operand width; matches accumulator data_in.
- ATTR_WIDTH, 4, attribute width; matches accumulator attr_in.
- CNT_WIDTH, 8, width of the operand count.
- HOLD_CYCLES, 2, clocks each operand is held with signal_load high; legal range is 1 to 15.

Ports:
- clk  in  1  system clock; all flops rise-edge.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  command strobe; sampled only in IDLE.
- count  in  CNT_WIDTH  number of operands in the burst; sampled with start.
- abort  in  1  cancels the burst in progress.
- op_valid  in  1  operand available.
- op_data  in  DATA_WIDTH  operand value.
- op_neg  in  1  operand is subtracted.
- op_ready  out  1  sequencer accepts an operand this cycle.
- signal_load  out  1  to accumulator.
- signal_init  out  1  to accumulator.
- signal_neg  out  1  to accumulator.
- signal_oe  out  1  to accumulator.
- data_out  out  DATA_WIDTH  to accumulator data_in.
- attr_out  out  ATTR_WIDTH  to accumulator attr_in; index of the current operand.
- busy  out  1  burst in progress.
- done  out  1  one-cycle completion pulse.
- aborted  out  1  one-cycle abort pulse.

Behaviour:
- All outputs are registered. On rst, every output is 0, state is IDLE and all counters are 0. Reset asserted mid-burst takes effect immediately; no done or aborted pulse follows.
- IDLE:
  - All outputs 0.
  - start=1 with count!=0: latch count into remaining, clear index, set first=1, go to FETCH.
  - start=1 with count==0: done=1 next cycle, no datapath activity, stay in IDLE.
- FETCH:
  - busy=1, op_ready=1, signal_load=0, signal_init=0, signal_oe=0.
  - On op_valid & op_ready at an edge: latch op_data into data_out, op_neg into signal_neg, index into attr_out; load hold counter = HOLD_CYCLES-1; go to APPLY.
- APPLY:
  - busy=1, op_ready=0, signal_load=1, data_out, signal_neg and attr_out stable.
  - signal_init=1 only in the first APPLY cycle of the first operand; first is then cleared.
  - Hold counter decrements each cycle. When it reaches 0: decrement remaining and increment index (wraps modulo 2^ATTR_WIDTH).
  - If remaining is now 0, go to OUT; otherwise go to FETCH.
- OUT: signal_oe=1 and done=1 for exactly one cycle, then IDLE. busy=0 from IDLE onward.
- Latency:
  - start sampled at edge T: op_ready high from T+1.
  - Handshake at edge E: signal_load high in cycles E+1 .. E+HOLD_CYCLES; FETCH or OUT at E+HOLD_CYCLES+1.
  - Minimum burst of N operands with op_valid held high: N*(HOLD_CYCLES+1)+2 cycles from start to done.
- Gap cycles: signal_load is 0 in every FETCH cycle. op_valid low stalls in FETCH indefinitely with no timeout.
- abort=1 in any non-IDLE state:
  - Next cycle: IDLE, all datapath outputs 0, aborted=1 for one cycle, done not pulsed.
  - abort has priority over a simultaneous handshake.
  - abort in IDLE is ignored.
- start while busy is ignored. done and aborted never assert together.
- signal_neg and data_out are cleared to 0 in IDLE and FETCH.

Test Plan:
- Burst of 4 operands (1,2,3,4), op_neg=0, HOLD_CYCLES=2, op_valid always high -> signal_load high in 4 pairs of cycles separated by single 0 cycles. signal_init high only in the first cycle, while data_out=1. attr_out steps 0,1,2,3. signal_oe and done high together for one cycle, 14 cycles after start.
- count=3, operands 5, 2 (op_neg=1), 7 -> signal_neg=1 only during the second operand's 2 APPLY cycles; done after the third operand.
- count=0 -> done high one cycle after start; signal_load, signal_init and signal_oe stay 0.
- count=2, op_valid low for 5 cycles after the first operand -> FETCH held with op_ready=1 and signal_load=0, then resumes; done follows normally.
- abort asserted in an APPLY cycle of operand 2 of 4 -> next cycle all outputs 0 and aborted=1, no done. A new start is accepted afterwards, and its first operand asserts signal_init again.
- rst asserted mid-APPLY, then released -> all outputs 0 immediately. A start of 17 operands gives attr_out wrapping 15->0 at operand 16.

Source files
------------

// File: rtl/acc_sequencer.sv
// Burst sequencer for the accumulator datapath: takes one operand per handshake,
// holds it on the datapath for HOLD_CYCLES clocks, then pulses output-enable and done.
module acc_sequencer #(
    parameter int DATA_WIDTH  = 8,
    parameter int ATTR_WIDTH  = 4,
    parameter int CNT_WIDTH   = 8,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  count,
    input  logic                  abort,
    input  logic                  op_valid,
    input  logic [DATA_WIDTH-1:0] op_data,
    input  logic                  op_neg,
    output logic                  op_ready,
    output logic                  signal_load,
    output logic                  signal_init,
    output logic                  signal_neg,
    output logic                  signal_oe,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [ATTR_WIDTH-1:0] attr_out,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted
);
    typedef enum logic [1:0] {IDLE, FETCH, APPLY, OUT} state_t;

    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  remaining_q, remaining_d;
    logic [ATTR_WIDTH-1:0] index_q, index_d;
    logic                  first_q, first_d;
    logic [3:0]            hold_q, hold_d;
    logic                  busy_q, busy_d;
    logic                  op_ready_q, op_ready_d;
    logic                  load_q, load_d;
    logic                  init_q, init_d;
    logic                  neg_q, neg_d;
    logic                  oe_q, oe_d;
    logic                  done_q, done_d;
    logic                  aborted_q, aborted_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [ATTR_WIDTH-1:0] attr_q, attr_d;

    // Outputs are decoded from the next state so they line up with the state they describe.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        index_d     = index_q;
        first_d     = first_q;
        hold_d      = hold_q;
        busy_d      = 1'b0;
        op_ready_d  = 1'b0;
        load_d      = 1'b0;
        init_d      = 1'b0;
        neg_d       = 1'b0;
        oe_d        = 1'b0;
        done_d      = 1'b0;
        aborted_d   = 1'b0;
        data_d      = '0;
        attr_d      = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (count != '0) begin
                        remaining_d = count;
                        index_d     = '0;
                        first_d     = 1'b1;
                        state_d     = FETCH;
                        busy_d      = 1'b1;
                        op_ready_d  = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            FETCH: begin
                if (abort) begin
                    state_d   = IDLE;
                    aborted_d = 1'b1;
                end else if (op_valid && op_ready_q) begin
                    state_d = APPLY;
                    hold_d  = HOLD_LAST;
                    busy_d  = 1'b1;
                    load_d  = 1'b1;
                    init_d  = first_q;
                    first_d = 1'b0;
                    neg_d   = op_neg;
                    data_d  = op_data;
                    attr_d  = index_q;
                end else begin
                    busy_d     = 1'b1;
                    op_ready_d = 1'b1;
                end
            end
            APPLY: begin
                if (abort) begin
                    state_d   = IDLE;
                    aborted_d = 1'b1;
                end else if (hold_q == 4'd0) begin
                    remaining_d = remaining_q - 1'b1;
                    index_d     = index_q + 1'b1;
                    busy_d      = 1'b1;
                    if (remaining_q == CNT_WIDTH'(1)) begin
                        state_d = OUT;
                        oe_d    = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        state_d    = FETCH;
                        op_ready_d = 1'b1;
                    end
                end else begin
                    hold_d = hold_q - 1'b1;
                    busy_d = 1'b1;
                    load_d = 1'b1;
                    neg_d  = neg_q;
                    data_d = data_q;
                    attr_d = attr_q;
                end
            end
            OUT: begin
                state_d   = IDLE;
                aborted_d = abort;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            index_q     <= '0;
            first_q     <= 1'b0;
            hold_q      <= '0;
            busy_q      <= 1'b0;
            op_ready_q  <= 1'b0;
            load_q      <= 1'b0;
            init_q      <= 1'b0;
            neg_q       <= 1'b0;
            oe_q        <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            data_q      <= '0;
            attr_q      <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            index_q     <= index_d;
            first_q     <= first_d;
            hold_q      <= hold_d;
            busy_q      <= busy_d;
            op_ready_q  <= op_ready_d;
            load_q      <= load_d;
            init_q      <= init_d;
            neg_q       <= neg_d;
            oe_q        <= oe_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
            data_q      <= data_d;
            attr_q      <= attr_d;
        end
    end

    assign op_ready    = op_ready_q;
    assign signal_load = load_q;
    assign signal_init = init_q;
    assign signal_neg  = neg_q;
    assign signal_oe   = oe_q;
    assign data_out    = data_q;
    assign attr_out    = attr_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign aborted     = aborted_q;
endmodule

// File: tb/tb_acc_sequencer.sv
// Scoreboard bench for acc_sequencer: stimulus queues the expected cycle-by-cycle
// output records, a negedge monitor pops and compares whenever any output is active.
module tb_acc_sequencer;
    localparam int HOLD = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] count;
    logic       abort;
    logic       op_valid;
    logic [7:0] op_data;
    logic       op_neg;
    logic       op_ready, signal_load, signal_init, signal_neg, signal_oe;
    logic [7:0] data_out;
    logic [3:0] attr_out;
    logic       busy, done, aborted;

    acc_sequencer #(
        .DATA_WIDTH(8), .ATTR_WIDTH(4), .CNT_WIDTH(8), .HOLD_CYCLES(HOLD)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .count(count), .abort(abort),
        .op_valid(op_valid), .op_data(op_data), .op_neg(op_neg),
        .op_ready(op_ready), .signal_load(signal_load), .signal_init(signal_init),
        .signal_neg(signal_neg), .signal_oe(signal_oe), .data_out(data_out),
        .attr_out(attr_out), .busy(busy), .done(done), .aborted(aborted)
    );

    always #5 clk = ~clk;

    // flag order: {busy, op_ready, load, init, neg, oe, done, aborted}
    typedef struct {
        int         cyc;
        logic [7:0] flags;
        logic [7:0] data;
        logic [3:0] attr;
    } rec_t;

    localparam logic [7:0] F_FETCH = 8'b1100_0000;
    localparam logic [7:0] F_OUT   = 8'b1000_0110;
    localparam logic [7:0] F_ABORT = 8'b0000_0001;
    localparam logic [7:0] F_DONE0 = 8'b0000_0010;

    rec_t       exp_q[$];
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    logic       end_req = 1'b0;
    logic       end_done = 1'b0;
    logic [7:0] op_d [0:31];
    logic       op_n [0:31];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void push(input int c, input logic [7:0] f, input logic [7:0] d, input logic [3:0] a);
        rec_t r;
        r.cyc = c; r.flags = f; r.data = d; r.attr = a;
        exp_q.push_back(r);
    endfunction

    always @(negedge clk) begin
        logic [7:0] gf;
        logic [3:0] ga, wa;
        rec_t e;
        gf = {busy, op_ready, signal_load, signal_init, signal_neg, signal_oe, done, aborted};
        if (rst) begin
            total++;
            if (gf != 8'h00 || data_out != 8'h00 || attr_out != 4'h0) begin
                bad++;
                $display("FAIL reset_outputs cyc=%0d got flags=%b data=%h attr=%h want all zero",
                         cyc, gf, data_out, attr_out);
            end
        end else if (gf != 8'h00 || data_out != 8'h00) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_output cyc=%0d got flags=%b data=%h attr=%h want idle",
                         cyc, gf, data_out, attr_out);
            end else begin
                e  = exp_q.pop_front();
                ga = e.flags[5] ? attr_out : 4'h0;
                wa = e.flags[5] ? e.attr : 4'h0;
                if (e.cyc != cyc || e.flags != gf || e.data != data_out || wa != ga) begin
                    bad++;
                    $display("FAIL seq got cyc=%0d flags=%b data=%h attr=%h want cyc=%0d flags=%b data=%h attr=%h",
                             cyc, gf, data_out, ga, e.cyc, e.flags, e.data, wa);
                end
            end
        end
        if (end_req && !end_done) begin
            end_done = 1'b1;
            total++;
            if (exp_q.size() != 0) begin
                bad++;
                $display("FAIL missing_outputs got pending=%0d want 0 (next want cyc=%0d)",
                         exp_q.size(), exp_q[0].cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one burst; gap_op stalls op_valid before that operand, abort_op/rst_op
    // interrupt in the first APPLY cycle of that operand (-1 disables).
    task automatic run_burst(input int n, input int gap_op, input int gap_len,
                             input int abort_op, input int rst_op);
        tick();
        start = 1'b1;
        count = 8'(n);
        tick();
        start = 1'b0;
        count = 8'd0;
        if (n == 0) begin
            push(cyc, F_DONE0, 8'h00, 4'h0);
            tick();
            return;
        end
        for (int i = 0; i < n; i++) begin
            if (i == gap_op) begin
                for (int k = 0; k < gap_len; k++) begin
                    push(cyc, F_FETCH, 8'h00, 4'h0);
                    tick();
                end
            end
            push(cyc, F_FETCH, 8'h00, 4'h0);
            op_valid = 1'b1;
            op_data  = op_d[i];
            op_neg   = op_n[i];
            tick();
            op_valid = 1'b0;
            op_data  = 8'hA5;
            op_neg   = 1'b1;
            for (int h = 0; h < HOLD; h++) begin
                if (i == rst_op) begin
                    rst = 1'b1;
                    tick();
                    tick();
                    rst = 1'b0;
                    return;
                end
                push(cyc, {3'b101, (i == 0 && h == 0), op_n[i], 3'b000}, op_d[i], 4'(i));
                if (i == abort_op) begin
                    abort = 1'b1;
                    tick();
                    abort = 1'b0;
                    push(cyc, F_ABORT, 8'h00, 4'h0);
                    tick();
                    return;
                end
                tick();
            end
        end
        push(cyc, F_OUT, 8'h00, 4'h0);
        tick();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; count = 8'd0; abort = 1'b0;
        op_valid = 1'b0; op_data = 8'h00; op_neg = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // 4 operands 1..4: done/oe land 14 cycles after start, counting the start cycle
        for (int i = 0; i < 4; i++) begin op_d[i] = 8'(i + 1); op_n[i] = 1'b0; end
        run_burst(4, -1, 0, -1, -1);
        tick();

        op_d[0] = 8'd5; op_n[0] = 1'b0;
        op_d[1] = 8'd2; op_n[1] = 1'b1;
        op_d[2] = 8'd7; op_n[2] = 1'b0;
        run_burst(3, -1, 0, -1, -1);
        tick();

        run_burst(0, -1, 0, -1, -1);
        tick();

        // abort in IDLE must produce no activity
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();

        op_d[0] = 8'h3C; op_n[0] = 1'b1;
        op_d[1] = 8'hC3; op_n[1] = 1'b0;
        run_burst(2, 1, 5, -1, -1);
        tick();

        for (int i = 0; i < 4; i++) begin op_d[i] = 8'(8'h10 + i); op_n[i] = i[0]; end
        run_burst(4, -1, 0, 1, -1);
        tick();
        op_d[0] = 8'h55; op_n[0] = 1'b0;
        op_d[1] = 8'hAA; op_n[1] = 1'b1;
        run_burst(2, -1, 0, -1, -1);
        tick();

        run_burst(3, -1, 0, -1, 1);
        tick();

        for (int i = 0; i < 17; i++) begin op_d[i] = 8'(8'h20 + i); op_n[i] = 1'b0; end
        run_burst(17, -1, 0, -1, -1);
        repeat (3) tick();

        end_req = 1'b1;
        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
